// File: rtl/usb_cmd_pkg.sv
// Shared constants and FSM state encoding for the USB RX command parser.
package usb_cmd_pkg;

    localparam logic [7:0] SOF0 = 8'hAA;
    localparam logic [7:0] SOF1 = 8'h55;

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        CMD,
        LENH,
        LENL,
        PAYLOAD,
        CHK
    } state_t;

endpackage

// File: rtl/usb_rx_cmd_parser.sv
// Frames RX FIFO bytes into commands: AA 55 CMD LEN_H LEN_L payload CHK.
module usb_rx_cmd_parser #(
    parameter int MAX_LEN     = 256,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_read,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_len,
    output logic        pl_valid,
    output logic [7:0]  pl_data,
    output logic        pl_last,
    input  logic        pl_ready,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code
);
    import usb_cmd_pkg::*;

    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic        rd_pend;
    logic        byte_v;
    logic [7:0]  byte_reg;
    logic [7:0]  chk;
    logic [7:0]  len_h;
    logic [7:0]  code_hold;
    logic [15:0] to_cnt;
    logic [15:0] rem;
    logic [15:0] len;
    logic        consume;
    logic        timeout;

    assign len     = {len_h, byte_reg};
    assign consume = byte_v && (state != PAYLOAD || pl_ready);
    assign timeout = state != IDLE && !byte_v && to_cnt == TO_LAST;

    // One read in flight; refill only when the holding register frees up.
    assign fifo_read = !RST && !fifo_empty && !rd_pend
                       && (!byte_v || consume);

    assign pl_valid = byte_v && state == PAYLOAD;
    assign pl_data  = byte_reg;
    assign pl_last  = pl_valid && rem == 16'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rd_pend   <= 1'b0;
            byte_v    <= 1'b0;
            byte_reg  <= '0;
            chk       <= '0;
            len_h     <= '0;
            code_hold <= '0;
            to_cnt    <= '0;
            rem       <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_len   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            rd_pend   <= fifo_read;
            cmd_valid <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;

            if (rd_pend) begin
                byte_reg <= fifo_data;
                byte_v   <= 1'b1;
            end else if (consume) begin
                byte_v <= 1'b0;
            end

            // A byte parked behind a stalled dispatcher is not idle time.
            if (state == IDLE || consume) begin
                to_cnt <= '0;
            end else if (!byte_v) begin
                to_cnt <= to_cnt + 16'd1;
            end

            if (timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_TO;
            end else if (consume) begin
                unique case (state)
                    IDLE: begin
                        if (byte_reg == SOF0) state <= SYNC;
                    end
                    SYNC: begin
                        if (byte_reg == SOF1)      state <= CMD;
                        else if (byte_reg != SOF0) state <= IDLE;
                    end
                    CMD: begin
                        code_hold <= byte_reg;
                        chk       <= byte_reg;
                        state     <= LENH;
                    end
                    LENH: begin
                        len_h <= byte_reg;
                        chk   <= chk + byte_reg;
                        state <= LENL;
                    end
                    LENL: begin
                        chk <= chk + byte_reg;
                        if (len > MAX_L) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= IDLE;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= code_hold;
                            cmd_len   <= len;
                            rem       <= len;
                            state     <= (len == 16'd0) ? CHK : PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        chk <= chk + byte_reg;
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) state <= CHK;
                    end
                    CHK: begin
                        if (byte_reg == chk) begin
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
